lsu: RTL and testbench

//  Load/store unit directly downstream of the ALU: takes the ALU sum (rs1+imm) as the effective address.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 208 ++++++++++++++++++++
 tb/tb_lsu.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// RV32I load/store encodings shared by the LSU: funct3 values, exception codes
// and the LSU state type.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_FAULT    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replicated data, load extraction
// with sign/zero extension, and misalignment/illegal-funct3 decode.
module lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_load       = w_shifted;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                // Unsigned variants exist only for loads
                o_illegal = i_store && i_funct3[2];
                o_be      = 4'b0001 << i_offset;
                o_wdata   = {4{i_wdata[7:0]}};
                o_load    = {{24{w_shifted[7] & ~i_funct3[2]}}, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                o_illegal    = i_store && i_funct3[2];
                o_misaligned = i_offset[0];
                o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_load       = {{16{w_shifted[15] & ~i_funct3[2]}}, w_shifted[15:0]};
            end
            F3_W: begin
                o_misaligned = |i_offset;
                o_be         = 4'b1111;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time over a req/ack memory port,
// results (extended load data or store completion plus exception) via valid/ready.
module lsu
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_store,
    output logic [1:0]  out_exc
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_store, w_store_next;
    logic [2:0]    r_funct3, w_funct3_next;
    logic [1:0]    r_off, w_off_next;
    logic [4:0]    r_rd, w_rd_next;
    logic          r_mem_req, w_mem_req_next;
    logic          r_mem_we, w_mem_we_next;
    logic [31:0]   r_mem_addr, w_mem_addr_next;
    logic [3:0]    r_mem_be, w_mem_be_next;
    logic [31:0]   r_mem_wdata, w_mem_wdata_next;
    logic          r_out_valid, w_out_valid_next;
    logic [31:0]   r_out_data, w_out_data_next;
    logic [4:0]    r_out_rd, w_out_rd_next;
    logic          r_out_store, w_out_store_next;
    logic [1:0]    r_out_exc, w_out_exc_next;

    logic          w_idle;
    logic [2:0]    w_funct3;
    logic [1:0]    w_off;
    logic          w_store;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_misaligned;
    logic          w_illegal;
    logic          w_timeout;

    // One aligner serves both issue-time decode and ack-time load extraction
    assign w_idle   = (r_state == IDLE);
    assign w_funct3 = w_idle ? in_funct3     : r_funct3;
    assign w_off    = w_idle ? in_addr[1:0]  : r_off;
    assign w_store  = w_idle ? in_store      : r_store;

    lsu_align u_align (
        .i_funct3     (w_funct3),
        .i_store      (w_store),
        .i_offset     (w_off),
        .i_wdata      (in_wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load       (w_load),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_store_next     = r_store;
        w_funct3_next    = r_funct3;
        w_off_next       = r_off;
        w_rd_next        = r_rd;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_be_next    = r_mem_be;
        w_mem_wdata_next = r_mem_wdata;
        w_out_valid_next = r_out_valid;
        w_out_data_next  = r_out_data;
        w_out_rd_next    = r_out_rd;
        w_out_store_next = r_out_store;
        w_out_exc_next   = r_out_exc;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_store_next  = in_store;
                    w_funct3_next = in_funct3;
                    w_off_next    = in_addr[1:0];
                    w_rd_next     = in_rd;
                    if (w_illegal || w_misaligned) begin
                        w_state_next     = RESP;
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = 32'h0;
                        w_out_rd_next    = in_rd;
                        w_out_store_next = in_store;
                        w_out_exc_next   = w_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                    end else begin
                        w_state_next     = REQ;
                        w_cnt_next       = '0;
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = in_store;
                        w_mem_addr_next  = {in_addr[31:2], 2'b00};
                        w_mem_be_next    = w_be;
                        w_mem_wdata_next = w_wdata;
                    end
                end
            end
            REQ: begin
                // An ack in the final timeout cycle still completes normally
                if (mem_ack || w_timeout) begin
                    w_state_next     = RESP;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_out_valid_next = 1'b1;
                    w_out_rd_next    = r_rd;
                    w_out_store_next = r_store;
                    if (mem_ack) begin
                        w_out_data_next = r_store ? 32'h0 : w_load;
                        w_out_exc_next  = EXC_OK;
                    end else begin
                        w_out_data_next = 32'h0;
                        w_out_exc_next  = EXC_FAULT;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_rd    <= 5'd0;
            r_out_store <= 1'b0;
            r_out_exc   <= EXC_OK;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_store     <= w_store_next;
            r_funct3    <= w_funct3_next;
            r_off       <= w_off_next;
            r_rd        <= w_rd_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_be    <= w_mem_be_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_rd    <= w_out_rd_next;
            r_out_store <= w_out_store_next;
            r_out_exc   <= w_out_exc_next;
        end
    end

    assign in_ready  = w_idle;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_store = r_out_store;
    assign out_exc   = r_out_exc;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-level memory model predicts every result and
// memory request; a responder plays the memory and a monitor checks writeback.
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_store;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, out_ready, out_store;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  out_exc;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_store  (in_store),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_store (out_store),
        .out_exc   (out_exc)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        store;
        logic [1:0]  exc;
        int          cyc;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          delay;
    } mexp_t;

    res_t        sb_q[$];
    mexp_t       mem_q[$];
    bit [31:0]   tbmem [bit [29:0]];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic bit [31:0] mem_word(input bit [31:0] a);
        if (!tbmem.exists(a[31:2])) tbmem[a[31:2]] = $urandom;
        return tbmem[a[31:2]];
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                fail_now("in_ready_wait");
                return;
            end
        end
    endtask

    // Called at a negedge; predicts the result from memory-model arithmetic.
    task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         input bit [4:0] rd, input int d, input bit expect_result);
        res_t        r;
        mexp_t       m;
        int          sz, off;
        bit          illegal, mis;
        bit [31:0]   w, v, mask;
        wait_idle();
        off = int'(a % 4);
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        mis = (a % sz) != 0;
        r.rd = rd;
        r.store = st;
        r.data = 32'h0;
        if (illegal || mis) begin
            r.exc = illegal ? 2'b11 : 2'b01;
            r.cyc = cyc + 1;
        end else begin
            m.addr = a & ~32'h3;
            m.we = st;
            m.delay = d;
            m.be = 4'b0000;
            m.wdata = 32'h0;
            r.exc = (d <= TO - 1) ? 2'b00 : 2'b10;
            r.cyc = cyc + 2 + ((d < TO - 1) ? d : TO - 1);
            w = mem_word(a);
            if (st) begin
                for (int i = 0; i < 4; i++) begin
                    m.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
                    if (i >= off && i < off + sz) begin
                        m.be[i] = 1'b1;
                        w[8*i +: 8] = wd[8*(i - off) +: 8];
                    end
                end
                if (r.exc == 2'b00) tbmem[a[31:2]] = w;
            end else begin
                mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
                v = (w >> (8 * off)) & mask;
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
                if (r.exc == 2'b00) r.data = v;
            end
            mem_q.push_back(m);
        end
        if (expect_result) sb_q.push_back(r);
        in_valid = 1'b1;
        in_store = st;
        in_funct3 = f3;
        in_addr = a;
        in_wdata = wd;
        in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0;
        in_addr = $urandom;
        in_wdata = $urandom;
        in_funct3 = 3'($urandom);
        in_store = 1'($urandom);
        in_rd = 5'($urandom);
    endtask

    // Memory responder: checks each request, acks after the planned delay, strays acks when idle.
    initial begin
        mexp_t m;
        bit    active = 1'b0;
        bit    known = 1'b0;
        int    c = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        m.delay = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (!rst_n) begin
                active = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    c = 0;
                    if (mem_q.size() == 0) begin
                        fail_now("unexpected_mem_req");
                        known = 1'b0;
                        m.delay = 0;
                        m.we = 1'b1;
                        m.addr = mem_addr;
                    end else begin
                        known = 1'b1;
                        m = mem_q.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        if (m.we) begin
                            chk("mem_be", 32'(mem_be), 32'(m.be));
                            chk("mem_wdata", mem_wdata, m.wdata);
                        end
                    end
                end
                if (known) chk("mem_addr", mem_addr, m.addr);
                if (c == m.delay) begin
                    mem_ack = 1'b1;
                    if (!m.we && tbmem.exists(m.addr[31:2])) mem_rdata = tbmem[m.addr[31:2]];
                end
                c++;
            end else begin
                if (active && known)
                    chk("mem_req_cycles", 32'(c), 32'(((m.delay < TO - 1) ? m.delay : TO - 1) + 1));
                active = 1'b0;
                if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
        end
    end

    // Writeback monitor: pops the scoreboard on each new result, then checks it holds while stalled.
    initial begin
        res_t        e;
        bit          holding = 1'b0;
        int          stall = 0;
        logic [31:0] s_data;
        logic [4:0]  s_rd;
        logic        s_store;
        logic [1:0]  s_exc;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (!holding) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_out_valid");
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_rd", 32'(out_rd), 32'(e.rd));
                        chk("out_store", 32'(out_store), 32'(e.store));
                        chk("out_exc", 32'(out_exc), 32'(e.exc));
                        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                        $display("txn rd=%0d store=%0b exc=%0d data=%08h cycle=%0d",
                                 out_rd, out_store, out_exc, out_data, cyc);
                    end
                    holding = 1'b1;
                    s_data = out_data;
                    s_rd = out_rd;
                    s_store = out_store;
                    s_exc = out_exc;
                    case ($urandom_range(0, 3))
                        0: stall = 0;
                        1: stall = 1;
                        2: stall = 5;
                        default: stall = $urandom_range(0, 3);
                    endcase
                end else begin
                    chk("hold_data", out_data, s_data);
                    chk("hold_rd", 32'(out_rd), 32'(s_rd));
                    chk("hold_store", 32'(out_store), 32'(s_store));
                    chk("hold_exc", 32'(out_exc), 32'(s_exc));
                end
                out_ready = (stall == 0);
                if (stall > 0) stall--;
                if (out_ready) holding = 1'b0;
            end else begin
                holding = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int guard;
        in_valid = 1'b0;
        in_store = 1'b0;
        in_funct3 = 3'b000;
        in_addr = 32'h0;
        in_wdata = 32'h0;
        in_rd = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_store", 32'(out_store), 32'd0);
        chk("rst_out_exc", 32'(out_exc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        wait_idle();
        tbmem[30'h40] = 32'hDEADBEEF;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 0, 1'b1);
        wait_idle();
        tbmem[30'h40] = 32'h80FFFFFF;
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd2, 0, 1'b1);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, 0, 1'b1);
        wait_idle();
        tbmem[30'h40] = 32'h80011234;
        issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd4, 0, 1'b1);
        issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd5, 1, 1'b1);
        issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd6, 0, 1'b1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd7, 0, 1'b1);
        issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd8, 9, 1'b1);
        issue(1'b0, 3'b010, 32'h108, 32'h0, 5'd9, TO - 1, 1'b1);

        for (int n = 0; n < 300; n++) begin
            bit [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000 + $urandom_range(0, 31);
            issue(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
                  $urandom_range(0, 5), 1'b1);
        end

        // Reset while the request is outstanding: abandon it, emit nothing
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd10, 50, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd11, 0, 1'b1);

        guard = 0;
        while (sb_q.size() != 0 || in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                fail_now("drain_timeout");
                break;
            end
        end
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
